// File: rtl/arb_pkg.sv
// Shared types and constants for the data RAM arbiter.
package arb_pkg;

   // Owner of the most recent grant; DMA_LOCKED marks a DMA burst under lock.
   typedef enum logic [1:0] {
      CORE_LAST  = 2'd0,
      DMA_LAST   = 2'd1,
      DMA_LOCKED = 2'd2
   } arb_state_t;

   // Port identifiers used by the read-return tag.
   localparam logic PORT_CORE = 1'b0;
   localparam logic PORT_DMA  = 1'b1;

   // Width of the burst counter.
   localparam int BURST_W = 8;

endpackage

// File: rtl/burst_counter.sv
// Saturating burst counter with clear, increment and a MAXBURST compare.
module burst_counter
   import arb_pkg::*;
#(
   parameter int MAXBURST = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               clr,
   input  logic               inc,
   output logic [BURST_W-1:0] count,
   output logic               at_max
);

   localparam logic [BURST_W-1:0] MAX_VAL = BURST_W'(MAXBURST);

   logic [BURST_W-1:0] count_reg;
   logic [BURST_W-1:0] count_next;

   // Clear wins over increment; increment stops at MAXBURST.
   always_comb begin
      count_next = count_reg;
      if (clr) begin
         count_next = '0;
      end else if (inc && (count_reg != MAX_VAL)) begin
         count_next = count_reg + 1'b1;
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   assign count  = count_reg;
   assign at_max = (count_reg == MAX_VAL);

endmodule

// File: rtl/dataram_arbiter.sv
// Shares the single-port data RAM between the core load/store port and the
// DMA port. Grants are combinational; round-robin with a bounded DMA lock.
module dataram_arbiter
   import arb_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MAXBURST = 8
) (
   input  logic             clock,
   input  logic             reset,
   // core port
   input  logic             c_req,
   input  logic             c_we,
   input  logic [WIDTH-1:0] c_addr,
   input  logic [WIDTH-1:0] c_wdata,
   output logic             c_gnt,
   output logic             c_rvalid,
   output logic             core_stall,
   // DMA port
   input  logic             d_req,
   input  logic             d_we,
   input  logic             d_lock,
   input  logic [WIDTH-1:0] d_addr,
   input  logic [WIDTH-1:0] d_wdata,
   output logic             d_gnt,
   output logic             d_rvalid,
   // shared read data
   output logic [WIDTH-1:0] rdata,
   // RAM side
   output logic             ram_en,
   output logic             ram_we,
   output logic [WIDTH-1:0] ram_addr,
   output logic [WIDTH-1:0] ram_wdata,
   input  logic [WIDTH-1:0] ram_rdata
);

   arb_state_t         state_reg;
   arb_state_t         state_next;
   logic               rd_valid_reg;
   logic               rd_port_reg;
   logic               cnt_clr;
   logic               cnt_inc;
   logic               burst_at_max;
   logic [BURST_W-1:0] burst_count;
   logic               dma_pref;

   burst_counter #(
      .MAXBURST (MAXBURST)
   ) u_burst (
      .clock  (clock),
      .reset  (reset),
      .clr    (cnt_clr),
      .inc    (cnt_inc),
      .count  (burst_count),
      .at_max (burst_at_max)
   );

   // Contention decision: DMA goes first after a core grant, or while a
   // locked burst has not yet used up its MAXBURST allowance.
   always_comb begin
      dma_pref = (state_reg == CORE_LAST) ||
                 ((state_reg == DMA_LOCKED) && !burst_at_max);
      c_gnt    = c_req && !(d_req && dma_pref);
      d_gnt    = d_req && !(c_req && !dma_pref);
   end

   // RAM mux: drive from whichever port is granted, zeros when idle.
   always_comb begin
      ram_en    = c_gnt || d_gnt;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (c_gnt) begin
         ram_we    = c_we;
         ram_addr  = c_addr;
         ram_wdata = c_wdata;
      end else if (d_gnt) begin
         ram_we    = d_we;
         ram_addr  = d_addr;
         ram_wdata = d_wdata;
      end
   end

   // Next owner and burst counter controls, evaluated on this cycle's grant.
   always_comb begin
      state_next = state_reg;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      if (c_gnt) begin
         state_next = CORE_LAST;
         cnt_clr    = 1'b1;
      end else if (d_gnt) begin
         if (d_lock) begin
            state_next = DMA_LOCKED;
            cnt_inc    = 1'b1;
         end else begin
            state_next = DMA_LAST;
            cnt_clr    = 1'b1;
         end
      end else if (!d_lock) begin
         cnt_clr = 1'b1;
      end
   end

   // Owner state and read-return tag; reset drops any outstanding rvalid.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg    <= CORE_LAST;
         rd_valid_reg <= 1'b0;
         rd_port_reg  <= PORT_CORE;
      end else begin
         state_reg    <= state_next;
         rd_valid_reg <= ram_en && !ram_we;
         rd_port_reg  <= d_gnt ? PORT_DMA : PORT_CORE;
      end
   end

   assign core_stall = c_req && !c_gnt;
   assign c_rvalid   = rd_valid_reg && (rd_port_reg == PORT_CORE);
   assign d_rvalid   = rd_valid_reg && (rd_port_reg == PORT_DMA);
   assign rdata      = ram_rdata;

endmodule

// File: tb/tb_dataram_arbiter.sv
// Self-checking bench for dataram_arbiter: directed steps then random traffic,
// checked against a transaction-level model of the arbitration rules.
module tb_dataram_arbiter;
   import arb_pkg::*;

   localparam int WIDTH    = 32;
   localparam int MAXBURST = 8;

   logic             clock = 1'b0;
   logic             reset;
   logic             c_req, c_we, c_gnt, c_rvalid, core_stall;
   logic [WIDTH-1:0] c_addr, c_wdata;
   logic             d_req, d_we, d_lock, d_gnt, d_rvalid;
   logic [WIDTH-1:0] d_addr, d_wdata;
   logic [WIDTH-1:0] rdata;
   logic             ram_en, ram_we;
   logic [WIDTH-1:0] ram_addr, ram_wdata, ram_rdata;

   logic [WIDTH-1:0] ram_mem [0:255];

   int checks = 0;
   int errors = 0;

   // model state
   bit               m_last_core = 1'b1;
   bit               m_locked    = 1'b0;
   int               m_burst     = 0;
   bit               m_pend_c    = 1'b0;
   bit               m_pend_d    = 1'b0;
   logic [WIDTH-1:0] m_exp_rdata = '0;
   logic [WIDTH-1:0] shadow [0:63];
   bit               obs_cg, obs_dg;

   dataram_arbiter #(
      .WIDTH    (WIDTH),
      .MAXBURST (MAXBURST)
   ) u_dut (
      .clock      (clock),
      .reset      (reset),
      .c_req      (c_req),
      .c_we       (c_we),
      .c_addr     (c_addr),
      .c_wdata    (c_wdata),
      .c_gnt      (c_gnt),
      .c_rvalid   (c_rvalid),
      .core_stall (core_stall),
      .d_req      (d_req),
      .d_we       (d_we),
      .d_lock     (d_lock),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_gnt      (d_gnt),
      .d_rvalid   (d_rvalid),
      .rdata      (rdata),
      .ram_en     (ram_en),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata)
   );

   always #5 clock = ~clock;

   // single-port RAM, one-cycle read latency
   always @(posedge clock) begin
      if (ram_en) begin
         if (ram_we) ram_mem[ram_addr[7:0]] <= ram_wdata;
         else        ram_rdata <= ram_mem[ram_addr[7:0]];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, check outputs against the model, advance model.
   task automatic cycle(input bit rst,
                        input bit creq, input bit cwe, input logic [31:0] caddr, input logic [31:0] cwd,
                        input bit dreq, input bit dwe, input bit dlk, input logic [31:0] daddr, input logic [31:0] dwd);
      bit ecg, edg;
      arb_state_t est;
      @(negedge clock);
      reset = rst; c_req = creq; c_we = cwe; c_addr = caddr; c_wdata = cwd;
      d_req = dreq; d_we = dwe; d_lock = dlk; d_addr = daddr; d_wdata = dwd;
      #1;
      // who should win
      ecg = 1'b0; edg = 1'b0;
      if (creq && !dreq) ecg = 1'b1;
      else if (dreq && !creq) edg = 1'b1;
      else if (creq && dreq) begin
         if (m_last_core) edg = 1'b1;
         else if (m_locked && (m_burst < MAXBURST)) edg = 1'b1;
         else ecg = 1'b1;
      end
      est = m_last_core ? CORE_LAST : (m_locked ? DMA_LOCKED : DMA_LAST);
      chk("c_gnt", c_gnt, ecg);
      chk("d_gnt", d_gnt, edg);
      chk("core_stall", core_stall, creq && !ecg);
      chk("ram_en", ram_en, ecg || edg);
      chk("ram_we", ram_we, ecg ? cwe : (edg ? dwe : 1'b0));
      chk("ram_addr", ram_addr, ecg ? caddr : (edg ? daddr : 32'd0));
      chk("ram_wdata", ram_wdata, ecg ? cwd : (edg ? dwd : 32'd0));
      chk("c_rvalid", c_rvalid, m_pend_c);
      chk("d_rvalid", d_rvalid, m_pend_d);
      if (m_pend_c || m_pend_d) chk("rdata", rdata, m_exp_rdata);
      chk("state", u_dut.state_reg, est);
      chk("burst", u_dut.burst_count, m_burst);
      obs_cg = c_gnt; obs_dg = d_gnt;
      // advance model
      m_pend_c = !rst && ecg && !cwe;
      m_pend_d = !rst && edg && !dwe;
      if (ecg && !cwe) m_exp_rdata = shadow[caddr[5:0]];
      if (edg && !dwe) m_exp_rdata = shadow[daddr[5:0]];
      if (ecg && cwe) shadow[caddr[5:0]] = cwd;
      if (edg && dwe) shadow[daddr[5:0]] = dwd;
      if (rst) begin
         m_last_core = 1'b1; m_locked = 1'b0; m_burst = 0;
      end else if (ecg) begin
         m_last_core = 1'b1; m_locked = 1'b0; m_burst = 0;
      end else if (edg) begin
         m_last_core = 1'b0; m_locked = dlk;
         m_burst = dlk ? ((m_burst < MAXBURST) ? m_burst + 1 : MAXBURST) : 0;
      end else if (!dlk) begin
         m_burst = 0;
      end
   endtask

   initial begin
      logic [3:0] pat;
      bit cp, cwe_r, dp, dwe_r;
      logic [31:0] ca, cd, da, dd;
      int cw, dw, max_cw, max_dw;

      reset = 1'b1; c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
      d_req = 0; d_we = 0; d_lock = 0; d_addr = 0; d_wdata = 0;

      // reset state
      cycle(1, 0,0,0,0, 0,0,0,0,0);
      cycle(0, 0,0,0,0, 0,0,0,0,0);

      // preload RAM through the DMA port
      for (int i = 0; i < 64; i++) cycle(0, 0,0,0,0, 1,1,0, i, 32'hA5000000 | i);

      // core-only read of 0x10 holding DEADBEEF
      cycle(0, 0,0,0,0, 1,1,0, 32'h10, 32'hDEADBEEF);
      cycle(0, 1,0,32'h10,0, 0,0,0,0,0);
      chk("tp1_c_gnt", c_gnt, 1'b1);
      chk("tp1_stall", core_stall, 1'b0);
      cycle(0, 0,0,0,0, 0,0,0,0,0);
      chk("tp1_rvalid", c_rvalid, 1'b1);
      chk("tp1_rdata", rdata, 32'hDEADBEEF);

      // both requesting, no lock: DMA, core, DMA, core
      cycle(1, 0,0,0,0, 0,0,0,0,0);
      pat = 4'b0101;
      for (int i = 0; i < 4; i++) begin
         cycle(0, 1,0,i,0, 1,0,0,i+4,0);
         chk("tp2_d_gnt", d_gnt, pat[i]);
         chk("tp2_stall", core_stall, pat[i]);
      end

      // locked DMA burst: 8 DMA grants, one core grant, DMA resumes
      cycle(1, 0,0,0,0, 0,0,0,0,0);
      for (int i = 0; i < 10; i++) begin
         cycle(0, 1,0,3,0, 1,0,1,i,0);
         chk("tp3_c_gnt", c_gnt, i == 8);
         if (i == 9) chk("tp3_burst_cleared", u_dut.burst_count, 32'd0);
      end

      // DMA write then core read of same address
      cycle(0, 0,0,0,0, 0,0,0,0,0);
      cycle(0, 0,0,0,0, 1,1,0, 32'h20, 32'h55);
      cycle(0, 1,0,32'h20,0, 0,0,0,0,0);
      chk("tp4_d_rvalid", d_rvalid, 1'b0);
      cycle(0, 0,0,0,0, 0,0,0,0,0);
      chk("tp4_c_rvalid", c_rvalid, 1'b1);
      chk("tp4_d_rvalid", d_rvalid, 1'b0);
      chk("tp4_rdata", rdata, 32'h55);

      // reset in the cycle of a granted core read
      cycle(0, 1,0,5,0, 1,0,1,6,0);
      cycle(1, 1,0,32'h10,0, 0,0,0,0,0);
      cycle(0, 0,0,0,0, 0,0,0,0,0);
      chk("tp5_c_rvalid", c_rvalid, 1'b0);
      chk("tp5_state", u_dut.state_reg, CORE_LAST);
      cycle(0, 1,0,1,0, 1,0,0,2,0);
      chk("tp5_dma_first", d_gnt, 1'b1);

      // random traffic, each requester holds its request until granted
      cp = 0; dp = 0; cw = 0; dw = 0; max_cw = 0; max_dw = 0;
      cwe_r = 0; dwe_r = 0; ca = 0; cd = 0; da = 0; dd = 0;
      for (int n = 0; n < 10000; n++) begin
         if (!cp && $urandom_range(0, 3) != 0) begin
            cp = 1; cwe_r = $urandom_range(0, 1) != 0;
            ca = $urandom_range(0, 63); cd = $urandom;
         end
         if (!dp && $urandom_range(0, 3) != 0) begin
            dp = 1; dwe_r = $urandom_range(0, 1) != 0;
            da = $urandom_range(0, 63); dd = $urandom;
         end
         cycle(0, cp, cwe_r, ca, cd, dp, dwe_r, $urandom_range(0, 3) != 0, da, dd);
         chk("rnd_exclusive", obs_cg && obs_dg, 1'b0);
         if (cp && !obs_cg) cw++; else cw = 0;
         if (dp && !obs_dg) dw++; else dw = 0;
         if (cw > max_cw) max_cw = cw;
         if (dw > max_dw) max_dw = dw;
         if (obs_cg) cp = 0;
         if (obs_dg) dp = 0;
      end
      cycle(0, 0,0,0,0, 0,0,0,0,0);
      chk("rnd_core_wait_bound", max_cw <= MAXBURST, 1'b1);
      chk("rnd_dma_wait_bound", max_dw <= 1, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
